// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - Shared state type, default size and address-width helpers for the matvec sequencer
package matvec_pkg;

   localparam int K_DEF = 8;

   typedef enum logic [2:0] {
      S_FIRST,
      S_LOAD_M,
      S_LOAD_X,
      S_ISSUE,
      S_DRAIN,
      S_OUT
   } state_t;

   function automatic int ma_w(input int k);
      return $clog2(k * k);
   endfunction

   function automatic int xa_w(input int k);
      return $clog2(k);
   endfunction

endpackage

// File: rtl/matvec_delay_line.sv
// rtl/matvec_delay_line.sv - Reset-clearable shift register aligning issue strobes with MAC operands
module matvec_delay_line #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/matvec_seq_ctrl.sv
// rtl/matvec_seq_ctrl.sv - KxK matrix-vector multiply control FSM; MATVEC_SEQ_PERF_EN adds perf counters
module matvec_seq_ctrl
   import matvec_pkg::*;
#(
   parameter int K      = K_DEF,
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
`ifdef MATVEC_SEQ_PERF_EN
   output logic [31:0]        perf_busy,
   output logic [15:0]        perf_rows,
`endif
   input  logic               input_valid,
   output logic               input_ready,
   input  logic               new_matrix,
   output logic               output_valid,
   input  logic               output_ready,
   output logic               m_we,
   output logic [ma_w(K)-1:0] m_waddr,
   output logic               x_we,
   output logic [xa_w(K)-1:0] x_waddr,
   output logic [ma_w(K)-1:0] m_raddr,
   output logic [xa_w(K)-1:0] x_raddr,
   output logic               acc_en,
   output logic               acc_clr
);

   localparam int MA_W = ma_w(K);
   localparam int XA_W = xa_w(K);

   state_t          r_state, w_next;
   logic [MA_W-1:0] r_mcnt;
   logic [XA_W-1:0] r_xcnt, r_row, r_k;
   logic [2:0]      r_dcnt;
   logic            w_in_xfer, w_out_xfer, w_issue;
   logic            w_m_last, w_x_last, w_k_last, w_d_last;
   logic [1:0]      w_acc;

   assign input_ready  = reset && (r_state == S_FIRST || r_state == S_LOAD_M || r_state == S_LOAD_X);
   assign output_valid = reset && (r_state == S_OUT);
   assign w_in_xfer    = input_valid && input_ready;
   assign w_out_xfer   = output_valid && output_ready;
   assign w_issue      = reset && (r_state == S_ISSUE);
   assign w_m_last     = (r_mcnt == MA_W'(K * K - 1));
   assign w_x_last     = (r_xcnt == XA_W'(K - 1));
   assign w_k_last     = (r_k == XA_W'(K - 1));
   assign w_d_last     = (r_dcnt == 3'(RD_LAT - 1));

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_FIRST;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FIRST:  if (w_in_xfer) w_next = new_matrix ? S_LOAD_M : S_LOAD_X;
         S_LOAD_M: if (w_in_xfer && w_m_last) w_next = S_LOAD_X;
         S_LOAD_X: if (w_in_xfer && w_x_last) w_next = S_ISSUE;
         S_ISSUE:  if (w_k_last) w_next = S_DRAIN;
         S_DRAIN:  if (w_d_last) w_next = S_OUT;
         S_OUT:    if (w_out_xfer) w_next = (r_row == XA_W'(K - 1)) ? S_FIRST : S_ISSUE;
         default:  w_next = S_FIRST;
      endcase
   end

   always_comb begin
      m_we    = w_in_xfer && ((r_state == S_FIRST && new_matrix) || r_state == S_LOAD_M);
      x_we    = w_in_xfer && ((r_state == S_FIRST && !new_matrix) || r_state == S_LOAD_X);
      m_waddr = (r_state == S_LOAD_M) ? r_mcnt : '0;
      x_waddr = (r_state == S_LOAD_X) ? r_xcnt : '0;
      m_raddr = {r_row, r_k};
      x_raddr = r_k;
      acc_en  = reset && w_acc[1];
      acc_clr = reset && w_acc[0];
   end

   // r_k wraps to zero after K-1 (K is a power of two), so S_OUT sees {row, 0}
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mcnt <= '0;
         r_xcnt <= '0;
         r_row  <= '0;
         r_k    <= '0;
         r_dcnt <= '0;
      end else begin
         case (r_state)
            S_FIRST: if (w_in_xfer) begin
               r_mcnt <= MA_W'(1);
               r_xcnt <= new_matrix ? '0 : XA_W'(1);
               r_row  <= '0;
               r_k    <= '0;
            end
            S_LOAD_M: if (w_in_xfer) begin
               r_mcnt <= r_mcnt + MA_W'(1);
               if (w_m_last) r_xcnt <= '0;
            end
            S_LOAD_X: if (w_in_xfer) r_xcnt <= r_xcnt + XA_W'(1);
            S_ISSUE: begin
               r_k    <= r_k + XA_W'(1);
               r_dcnt <= '0;
            end
            S_DRAIN: r_dcnt <= r_dcnt + 3'd1;
            S_OUT:   if (w_out_xfer) r_row <= r_row + XA_W'(1);
            default: ;
         endcase
      end
   end

   matvec_delay_line #(.WIDTH(2), .DEPTH(RD_LAT)) u_acc_dly (
      .i_clk     (clk),
      .i_reset_n (reset),
      .i_data    ({w_issue, w_issue && (r_k == '0)}),
      .o_data    (w_acc)
   );

`ifdef MATVEC_SEQ_PERF_EN
   logic [31:0] r_perf_busy;
   logic [15:0] r_perf_rows;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_perf_busy <= '0;
         r_perf_rows <= '0;
      end else begin
         if (r_state != S_FIRST && r_perf_busy != '1) r_perf_busy <= r_perf_busy + 32'd1;
         if (w_out_xfer && r_perf_rows != '1)         r_perf_rows <= r_perf_rows + 16'd1;
      end
   end

   assign perf_busy = r_perf_busy;
   assign perf_rows = r_perf_rows;
`endif

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// tb/tb_matvec_seq_ctrl.sv - Directed self-checking bench for matvec_seq_ctrl (K=8, RD_LAT=1)
module tb_matvec_seq_ctrl;

   localparam int K = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       input_valid = 1'b0;
   logic       new_matrix = 1'b0;
   logic       output_ready = 1'b0;
   logic       input_ready, output_valid, m_we, x_we, acc_en, acc_clr;
   logic [5:0] m_waddr, m_raddr;
   logic [2:0] x_waddr, x_raddr;
`ifdef MATVEC_SEQ_PERF_EN
   logic [31:0] perf_busy;
   logic [15:0] perf_rows;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   matvec_seq_ctrl #(.K(K), .RD_LAT(1)) dut (
      .clk          (clk),
      .reset        (reset),
`ifdef MATVEC_SEQ_PERF_EN
      .perf_busy    (perf_busy),
      .perf_rows    (perf_rows),
`endif
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .new_matrix   (new_matrix),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .m_we         (m_we),
      .m_waddr      (m_waddr),
      .x_we         (x_we),
      .x_waddr      (x_waddr),
      .m_raddr      (m_raddr),
      .x_raddr      (x_raddr),
      .acc_en       (acc_en),
      .acc_clr      (acc_clr)
   );

   // Every cycle body starts 1 time unit after a posedge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int n, input bit nm);
      for (int w = 0; w < n; w++) begin
         input_valid = 1'b1;
         new_matrix  = (w == 0) ? nm : 1'b0;
         cyc();
      end
      input_valid = 1'b0;
      new_matrix  = 1'b0;
   endtask

   // Row model: issue j=0..7 (acc_en j>=1, acc_clr j==1), drain j=8, output_valid j=9 onward
   task automatic run_rows(input int r0, input int stall, output int errs, output int outs);
      errs = 0;
      outs = 0;
      for (int r = r0; r < K; r++) begin
         int st;
         st = (r == r0) ? stall : 0;
         for (int j = 0; j < 9; j++) begin
            output_ready = 1'b1;
            #1;
            if (input_ready !== 1'b0 || output_valid !== 1'b0 || m_we !== 1'b0 || x_we !== 1'b0) errs++;
            if (acc_en !== (j >= 1) || acc_clr !== (j == 1)) errs++;
            if (j < 8 && (m_raddr !== 6'(r * K + j) || x_raddr !== 3'(j))) errs++;
            cyc();
         end
         for (int s = 0; s <= st; s++) begin
            output_ready = (s < st) ? 1'b0 : 1'b1;
            #1;
            if (output_valid !== 1'b1 || acc_en !== 1'b0 || m_raddr !== 6'(r * K)) errs++;
            if (output_ready) outs++;
            cyc();
         end
      end
      output_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      input_valid = 1'b1;
      new_matrix = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_chk++;
         if (input_ready !== 1'b0 || m_we !== 1'b0 || output_valid !== 1'b0 || acc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold c=%0d: ready=%b m_we=%b ov=%b acc_en=%b, required all 0",
                     c, input_ready, m_we, output_valid, acc_en);
         end
         cyc();
      end
      reset = 1'b1;
      input_valid = 1'b0;
      new_matrix = 1'b0;
      #1;
      n_chk++;
      if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b ov=%b, required 1/0", input_ready, output_valid);
      end
      cyc();
   endtask

   task automatic test_full_problem();
      int bad_m, bad_x, errs, outs;
      bad_m = 0;
      bad_x = 0;
      for (int w = 0; w < 72; w++) begin
         input_valid = 1'b1;
         new_matrix = (w == 0);
         #1;
         if (input_ready !== 1'b1) bad_m++;
         if (w < 64) begin
            if (m_we !== 1'b1 || x_we !== 1'b0 || m_waddr !== 6'(w)) bad_m++;
         end else begin
            if (x_we !== 1'b1 || m_we !== 1'b0 || x_waddr !== 3'(w - 64)) bad_x++;
         end
         cyc();
      end
      input_valid = 1'b0;
      new_matrix = 1'b0;
      n_chk++;
      if (bad_m !== 0) begin
         n_fail++;
         $display("FAIL full_matrix_load: %0d bad cycles, required 0", bad_m);
      end
      n_chk++;
      if (bad_x !== 0) begin
         n_fail++;
         $display("FAIL full_vector_load: %0d bad cycles, required 0", bad_x);
      end
      run_rows(0, 0, errs, outs);
      n_chk++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL full_rows_timing: %0d deviations, required 0", errs);
      end
      n_chk++;
      if (outs !== 8) begin
         n_fail++;
         $display("FAIL full_rows_count: got %0d outputs, required 8", outs);
      end
      #1;
      n_chk++;
      if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_back_to_first: ready=%b ov=%b, required 1/0", input_ready, output_valid);
      end
      cyc();
   endtask

   task automatic test_vector_only();
      int bad, errs, outs;
      bad = 0;
      for (int w = 0; w < 8; w++) begin
         input_valid = 1'b1;
         new_matrix = 1'b0;
         #1;
         if (m_we !== 1'b0 || x_we !== 1'b1 || x_waddr !== 3'(w)) bad++;
         cyc();
      end
      input_valid = 1'b0;
      n_chk++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL vec_load: %0d bad cycles, required 0", bad);
      end
      run_rows(0, 0, errs, outs);
      n_chk++;
      if (errs !== 0 || outs !== 8) begin
         n_fail++;
         $display("FAIL vec_rows: errs=%0d outs=%0d, required 0/8", errs, outs);
      end
   endtask

   task automatic test_backpressure();
      int errs, outs;
      load(8, 1'b0);
      run_rows(0, 5, errs, outs);
      n_chk++;
      if (errs !== 0) begin
         n_fail++;
         $display("FAIL stall_rows: %0d deviations, required 0", errs);
      end
      n_chk++;
      if (outs !== 8) begin
         n_fail++;
         $display("FAIL stall_count: got %0d outputs, required 8", outs);
      end
   endtask

   task automatic test_toggle();
      int bad, errs, outs;
      bad = 0;
      for (int c = 0; c < 15; c++) begin
         input_valid = (c % 2 == 0);
         new_matrix = (c != 0);
         #1;
         if (m_we !== 1'b0 || input_ready !== 1'b1) bad++;
         if (input_valid && (x_we !== 1'b1 || x_waddr !== 3'(c / 2))) bad++;
         if (!input_valid && x_we !== 1'b0) bad++;
         cyc();
      end
      input_valid = 1'b0;
      new_matrix = 1'b0;
      n_chk++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL toggle_load: %0d bad cycles, required 0", bad);
      end
      run_rows(0, 0, errs, outs);
      n_chk++;
      if (errs !== 0 || outs !== 8) begin
         n_fail++;
         $display("FAIL toggle_rows: errs=%0d outs=%0d, required 0/8", errs, outs);
      end
   endtask

   task automatic test_reset_mid();
      load(8, 1'b0);
      output_ready = 1'b1;
      for (int c = 0; c < 33; c++) cyc();
      #1;
      n_chk++;
      if (m_raddr !== 6'd27 || acc_en !== 1'b1 || input_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_issue_pos: m_raddr=%0d acc_en=%b ready=%b, required 27/1/0",
                  m_raddr, acc_en, input_ready);
      end
      reset = 1'b0;
      output_ready = 1'b0;
      #1;
      n_chk++;
      if (acc_en !== 1'b0 || acc_clr !== 1'b0 || output_valid !== 1'b0 || input_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_low: acc_en=%b acc_clr=%b ov=%b ready=%b, required 0",
                  acc_en, acc_clr, output_valid, input_ready);
      end
      cyc();
      reset = 1'b1;
      #1;
      n_chk++;
      if (input_ready !== 1'b1 || acc_en !== 1'b0 || output_valid !== 1'b0 || m_raddr !== 6'd0) begin
         n_fail++;
         $display("FAIL mid_reset_after: ready=%b acc_en=%b ov=%b m_raddr=%0d, required 1/0/0/0",
                  input_ready, acc_en, output_valid, m_raddr);
      end
      cyc();
      test_full_problem();
   endtask

   initial begin
      #1;
      test_reset();
      test_full_problem();
`ifdef MATVEC_SEQ_PERF_EN
      n_chk++;
      if (perf_rows !== 16'd8) begin
         n_fail++;
         $display("FAIL perf_rows: got %0d, required 8", perf_rows);
      end
`endif
      test_vector_only();
      test_backpressure();
      test_toggle();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
